el2_pmp_csr: RTL and testbench

- Machine-mode CSR storage for the PMP entries: pmpcfg0-3 and pmpaddr0-15.
- Applies the WARL, lock and TOR-lock rules to CSR writes.
- Drives the configuration and address buses consumed directly by the PMP checker (el2_pmp).
- Sits between the core's CSR read/write path and the PMP checker. Provides a registered read path and a change-notification pulse so fetch/LSU can flush stale permission results.

---
 rtl/el2_pmp_csr_if.sv | 19 +
 rtl/el2_pmp_csr.sv | 84 ++++++++
 tb/tb_el2_pmp_csr.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/el2_pmp_csr_if.sv
// el2_pmp_csr_if: CSR read/write bus between the core CSR path and the PMP CSR block
interface el2_pmp_csr_if;
    logic        csr_wr_en;
    logic        csr_rd_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_hit;
    modport master (
        output csr_wr_en, csr_rd_en, csr_addr, csr_wdata, csr_op,
        input  csr_rdata, csr_rvalid, csr_hit
    );
    modport slave (
        input  csr_wr_en, csr_rd_en, csr_addr, csr_wdata, csr_op,
        output csr_rdata, csr_rvalid, csr_hit
    );
endinterface

// File: rtl/el2_pmp_csr.sv
// el2_pmp_csr: pmpcfg/pmpaddr CSR storage with WARL, lock and TOR-lock write rules
module el2_pmp_csr #(
    parameter int PMP_ENTRIES     = 16,
    parameter int PMP_GRANULARITY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    el2_pmp_csr_if.slave             bus,
    output logic [8*PMP_ENTRIES-1:0]  pmp_cfg,
    output logic [32*PMP_ENTRIES-1:0] pmp_addr,
    output logic                     pmp_update
);
    localparam int E = PMP_ENTRIES;
    localparam int G = PMP_GRANULARITY;
    localparam logic [31:0] SET_MASK = (32'd1 << (G >= 2 ? G - 1 : 0)) - 32'd1;
    localparam logic [31:0] CLR_MASK = (32'd1 << G) - 32'd1;

    logic [8*E-1:0]  cfg_q, cfg_d;
    logic [32*E-1:0] addr_q, addr_d;
    logic            is_cfg, is_addr, wr;
    logic [31:0]     old_word, new_word, rd_word;

    // decode the address and gather the raw (for modify) and read-view words
    always_comb begin
        is_cfg   = bus.csr_addr[11:2] == 10'h0E8;
        is_addr  = bus.csr_addr[11:4] == 8'h3B;
        wr       = bus.csr_wr_en && bus.csr_op != 2'd3 && (is_cfg || is_addr);
        old_word = '0;
        rd_word  = '0;
        for (int i = 0; i < E; i++) begin
            if (is_cfg && bus.csr_addr[1:0] == 2'(i / 4)) begin
                old_word[8*(i%4)+:8] = cfg_q[8*i+:8];
                rd_word[8*(i%4)+:8]  = cfg_q[8*i+:8];
            end
            if (is_addr && bus.csr_addr[3:0] == 4'(i)) begin
                old_word = addr_q[32*i+:32];
                rd_word  = cfg_q[8*i+3+:2] == 2'd3 ? addr_q[32*i+:32] | SET_MASK :
                           !cfg_q[8*i+4]           ? addr_q[32*i+:32] & ~CLR_MASK :
                                                     addr_q[32*i+:32];
            end
        end
        new_word = bus.csr_op == 2'd0 ? bus.csr_wdata :
                   bus.csr_op == 2'd1 ? old_word | bus.csr_wdata :
                                        old_word & ~bus.csr_wdata;
    end

    // apply lock, reserved-RW, NA4 and TOR-lock rules per entry using pre-write state
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        for (int i = 0; i < E; i++) begin
            logic [7:0] ob, nb;
            ob = cfg_q[8*i+:8];
            nb = new_word[8*(i%4)+:8];
            if (wr && is_cfg && bus.csr_addr[1:0] == 2'(i / 4) && !ob[7] && !(!nb[0] && nb[1]))
                cfg_d[8*i+:8] = {nb[7], 2'b00, (G >= 1 && nb[4:3] == 2'd2) ? ob[4:3] : nb[4:3], nb[2:0]};
            if (wr && is_addr && bus.csr_addr[3:0] == 4'(i) && !ob[7] &&
                !(i + 1 < E && cfg_q[8*((i+1)%E)+7] && cfg_q[8*((i+1)%E)+3+:2] == 2'd1))
                addr_d[32*i+:32] = new_word;
        end
    end

    // state, change pulse and one-cycle registered read response
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q          <= '0;
            addr_q         <= '0;
            pmp_update     <= 1'b0;
            bus.csr_rvalid <= 1'b0;
            bus.csr_hit    <= 1'b0;
            bus.csr_rdata  <= '0;
        end else begin
            cfg_q          <= cfg_d;
            addr_q         <= addr_d;
            pmp_update     <= (cfg_d != cfg_q) || (addr_d != addr_q);
            bus.csr_rvalid <= bus.csr_rd_en;
            bus.csr_hit    <= bus.csr_rd_en && (is_cfg || is_addr);
            bus.csr_rdata  <= bus.csr_rd_en ? rd_word : 32'd0;
        end
    end

    assign pmp_cfg  = cfg_q;
    assign pmp_addr = addr_q;
endmodule

// File: tb/tb_el2_pmp_csr.sv
// tb_el2_pmp_csr: directed checks of three PMP CSR configurations driven in lockstep
module tb_el2_pmp_csr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  op = 2'd3;
    int          checks = 0, errors = 0;
    logic [31:0] rd0, rd2, rd8;
    logic        hit0, hit2, hit8, val0;

    logic [127:0] cfg0, cfg2;
    logic [63:0]  cfg8;
    logic [511:0] addr0, addr2;
    logic [255:0] addr8;
    logic         upd0, upd2, upd8;

    el2_pmp_csr_if b0 ();
    el2_pmp_csr_if b2 ();
    el2_pmp_csr_if b8 ();

    assign b0.csr_wr_en = wr_en; assign b0.csr_rd_en = rd_en; assign b0.csr_addr = addr; assign b0.csr_wdata = wdata; assign b0.csr_op = op;
    assign b2.csr_wr_en = wr_en; assign b2.csr_rd_en = rd_en; assign b2.csr_addr = addr; assign b2.csr_wdata = wdata; assign b2.csr_op = op;
    assign b8.csr_wr_en = wr_en; assign b8.csr_rd_en = rd_en; assign b8.csr_addr = addr; assign b8.csr_wdata = wdata; assign b8.csr_op = op;

    el2_pmp_csr #(.PMP_ENTRIES(16), .PMP_GRANULARITY(0)) d0 (.clk(clk), .rst(rst), .bus(b0), .pmp_cfg(cfg0), .pmp_addr(addr0), .pmp_update(upd0));
    el2_pmp_csr #(.PMP_ENTRIES(16), .PMP_GRANULARITY(2)) d2 (.clk(clk), .rst(rst), .bus(b2), .pmp_cfg(cfg2), .pmp_addr(addr2), .pmp_update(upd2));
    el2_pmp_csr #(.PMP_ENTRIES(8),  .PMP_GRANULARITY(0)) d8 (.clk(clk), .rst(rst), .bus(b8), .pmp_cfg(cfg8), .pmp_addr(addr8), .pmp_update(upd8));

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d, input logic [1:0] o);
        @(negedge clk) begin wr_en = 1'b1; addr = a; wdata = d; op = o; end
        @(negedge clk) begin wr_en = 1'b0; op = 2'd3; end
    endtask

    task automatic csr_read(input logic [11:0] a);
        @(negedge clk) begin rd_en = 1'b1; addr = a; end
        @(negedge clk) rd_en = 1'b0;
        rd0 = b0.csr_rdata; rd2 = b2.csr_rdata; rd8 = b8.csr_rdata;
        hit0 = b0.csr_hit; hit2 = b2.csr_hit; hit8 = b8.csr_hit; val0 = b0.csr_rvalid;
    endtask

    task automatic test_reset();
        @(negedge clk) begin rst = 1'b1; wr_en = 1'b1; addr = 12'h3A0; wdata = 32'h0F; op = 2'd0; end
        @(negedge clk) begin rst = 1'b0; wr_en = 1'b0; op = 2'd3; end
        checks++; if (cfg0 !== '0) begin errors++; $display("FAIL reset_cfg got=%h exp=0", cfg0); end
        checks++; if (addr0 !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", addr0); end
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL reset_update got=%b exp=0", upd0); end
        checks++; if (b0.csr_rvalid !== 1'b0 || b0.csr_rdata !== 32'd0 || b0.csr_hit !== 1'b0) begin errors++; $display("FAIL reset_read got=%b/%h/%b exp=0/0/0", b0.csr_rvalid, b0.csr_rdata, b0.csr_hit); end
    endtask

    task automatic test_write_read();
        do_reset();
        csr_write(12'h3A0, 32'h0000_1F0F, 2'd0);
        checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL wr_update got=%b exp=1", upd0); end
        @(negedge clk);
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL wr_update_once got=%b exp=0", upd0); end
        checks++; if (cfg0[15:0] !== 16'h1F0F) begin errors++; $display("FAIL wr_cfg_bytes got=%h exp=1f0f", cfg0[15:0]); end
        csr_read(12'h3A0);
        checks++; if (rd0 !== 32'h0000_1F0F || hit0 !== 1'b1 || val0 !== 1'b1) begin errors++; $display("FAIL rd_cfg0 got=%h/%b/%b exp=00001f0f/1/1", rd0, hit0, val0); end
        @(negedge clk);
        checks++; if (b0.csr_rvalid !== 1'b0 || b0.csr_rdata !== 32'd0) begin errors++; $display("FAIL rd_hold got=%b/%h exp=0/0", b0.csr_rvalid, b0.csr_rdata); end
    endtask

    task automatic test_warl();
        do_reset();
        csr_write(12'h3A0, 32'h01, 2'd0);
        csr_write(12'h3A0, 32'h02, 2'd0);
        checks++; if (cfg0[7:0] !== 8'h01 || upd0 !== 1'b0) begin errors++; $display("FAIL warl_rw got=%h/%b exp=01/0", cfg0[7:0], upd0); end
        csr_write(12'h3A0, 32'hE3, 2'd0);
        checks++; if (cfg0[7:0] !== 8'h83) begin errors++; $display("FAIL warl_rsvd got=%h exp=83", cfg0[7:0]); end
    endtask

    task automatic test_lock();
        do_reset();
        csr_write(12'h3A0, 32'h0000_8900, 2'd0);
        csr_write(12'h3B0, 32'h1234, 2'd0);
        checks++; if (addr0[31:0] !== 32'd0 || upd0 !== 1'b0) begin errors++; $display("FAIL lock_tor got=%h/%b exp=0/0", addr0[31:0], upd0); end
        csr_write(12'h3B1, 32'h5678, 2'd0);
        checks++; if (addr0[63:32] !== 32'd0) begin errors++; $display("FAIL lock_addr got=%h exp=0", addr0[63:32]); end
        csr_write(12'h3A0, 32'h0, 2'd0);
        checks++; if (cfg0[15:0] !== 16'h8900 || upd0 !== 1'b0) begin errors++; $display("FAIL lock_cfg got=%h/%b exp=8900/0", cfg0[15:0], upd0); end
        do_reset();
        checks++; if (cfg0 !== '0) begin errors++; $display("FAIL lock_reset got=%h exp=0", cfg0); end
        csr_write(12'h3B0, 32'h1234, 2'd0);
        checks++; if (addr0[31:0] !== 32'h1234 || upd0 !== 1'b1) begin errors++; $display("FAIL lock_after_rst got=%h/%b exp=1234/1", addr0[31:0], upd0); end
    endtask

    task automatic test_granularity();
        do_reset();
        csr_write(12'h3B0, 32'h1000, 2'd0);
        csr_write(12'h3A0, 32'h19, 2'd0);
        csr_read(12'h3B0);
        checks++; if (rd2 !== 32'h1001) begin errors++; $display("FAIL g2_napot got=%h exp=1001", rd2); end
        checks++; if (rd0 !== 32'h1000) begin errors++; $display("FAIL g0_napot got=%h exp=1000", rd0); end
        csr_write(12'h3A0, 32'h09, 2'd0);
        csr_read(12'h3B0);
        checks++; if (rd2 !== 32'h1000) begin errors++; $display("FAIL g2_tor got=%h exp=1000", rd2); end
        csr_write(12'h3B0, 32'h1003, 2'd0);
        csr_read(12'h3B0);
        checks++; if (rd2 !== 32'h1000 || addr2[31:0] !== 32'h1003) begin errors++; $display("FAIL g2_tor_view got=%h/%h exp=1000/1003", rd2, addr2[31:0]); end
        csr_write(12'h3A0, 32'h11, 2'd0);
        checks++; if (cfg2[7:0] !== 8'h09) begin errors++; $display("FAIL g2_na4 got=%h exp=09", cfg2[7:0]); end
        checks++; if (cfg0[7:0] !== 8'h11) begin errors++; $display("FAIL g0_na4 got=%h exp=11", cfg0[7:0]); end
    endtask

    task automatic test_set_clear();
        do_reset();
        csr_write(12'h3A0, 32'h01, 2'd0);
        csr_write(12'h3A0, 32'h100, 2'd1);
        csr_read(12'h3A0);
        checks++; if (rd0 !== 32'h0101) begin errors++; $display("FAIL set_op got=%h exp=0101", rd0); end
        csr_write(12'h3A0, 32'h01, 2'd2);
        csr_read(12'h3A0);
        checks++; if (rd0 !== 32'h0100) begin errors++; $display("FAIL clear_op got=%h exp=0100", rd0); end
        csr_write(12'h3A0, 32'hFF, 2'd3);
        checks++; if (cfg0[15:0] !== 16'h0100 || upd0 !== 1'b0) begin errors++; $display("FAIL noop got=%h/%b exp=0100/0", cfg0[15:0], upd0); end
        @(negedge clk) begin rd_en = 1'b1; wr_en = 1'b1; addr = 12'h3A0; wdata = 32'h0F0F; op = 2'd0; end
        @(negedge clk) begin rd_en = 1'b0; wr_en = 1'b0; op = 2'd3; end
        checks++; if (b0.csr_rdata !== 32'h0100 || cfg0[15:0] !== 16'h0F0F) begin errors++; $display("FAIL rd_wr_same got=%h/%h exp=0100/0f0f", b0.csr_rdata, cfg0[15:0]); end
    endtask

    task automatic test_entries8();
        do_reset();
        csr_write(12'h3A3, 32'h0F0F_0F0F, 2'd0);
        checks++; if (cfg8 !== '0 || upd8 !== 1'b0) begin errors++; $display("FAIL e8_cfg3 got=%h/%b exp=0/0", cfg8, upd8); end
        checks++; if (cfg0[127:96] !== 32'h0F0F_0F0F) begin errors++; $display("FAIL e16_cfg3 got=%h exp=0f0f0f0f", cfg0[127:96]); end
        csr_read(12'h3A3);
        checks++; if (rd8 !== 32'd0 || hit8 !== 1'b1) begin errors++; $display("FAIL e8_rd_cfg3 got=%h/%b exp=0/1", rd8, hit8); end
        csr_write(12'h3BC, 32'hABCD, 2'd0);
        checks++; if (addr8 !== '0 || upd8 !== 1'b0) begin errors++; $display("FAIL e8_addr12 got=%h/%b exp=0/0", addr8[31:0], upd8); end
        csr_read(12'h3BC);
        checks++; if (rd8 !== 32'd0 || hit8 !== 1'b1 || rd0 !== 32'hABCD) begin errors++; $display("FAIL e8_rd_addr12 got=%h/%b/%h exp=0/1/abcd", rd8, hit8, rd0); end
        csr_write(12'h3C0, 32'hFFFF_FFFF, 2'd0);
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL miss_write got=%b exp=0", upd0); end
        csr_read(12'h3C0);
        checks++; if (hit0 !== 1'b0 || rd0 !== 32'd0 || val0 !== 1'b1 || hit2 !== 1'b0) begin errors++; $display("FAIL miss_read got=%b/%h/%b exp=0/0/1", hit0, rd0, val0); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_warl();
        test_lock();
        test_granularity();
        test_set_clear();
        test_entries8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
